// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Two-master (fetch / memory-stage) arbiter onto a single shared
//            bus, with anti-starvation for fetch and a bus watchdog.
// Revision : 1.0  initial release
// ============================================================================
module mem_arbiter #(
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        if_valid_i,
  input  logic [63:0] if_addr_i,
  input  logic [1:0]  if_size_i,
  output logic        if_ready_o,
  output logic [63:0] if_rdata_o,
  output logic [1:0]  if_resp_o,

  input  logic        me_valid_i,
  input  logic        me_req_i,
  input  logic [63:0] me_addr_i,
  input  logic [63:0] me_wdata_i,
  input  logic [1:0]  me_size_i,
  output logic        me_ready_o,
  output logic [63:0] me_rdata_o,
  output logic [1:0]  me_resp_o,

  output logic        bus_valid_o,
  output logic        bus_req_o,
  output logic [63:0] bus_addr_o,
  output logic [63:0] bus_wdata_o,
  output logic [1:0]  bus_size_o,
  input  logic        bus_ready_i,
  input  logic [63:0] bus_rdata_i,
  input  logic [1:0]  bus_resp_i
);

  localparam int SC_W = ($clog2(STARVE_MAX + 1) > 3) ? $clog2(STARVE_MAX + 1) : 3;
  localparam int WD_W = ($clog2(TIMEOUT + 1) > 1) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [SC_W-1:0] STARVE_LIMIT = SC_W'(STARVE_MAX);
  localparam logic [WD_W-1:0] WDOG_LAST    = WD_W'(TIMEOUT - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_GNT_IF = 2'd1;
  localparam logic [1:0] S_GNT_ME = 2'd2;

  logic [1:0]      state_q,  state_d;
  logic [SC_W-1:0] starve_q, starve_d;
  logic [WD_W-1:0] wdog_q,   wdog_d;
  logic [63:0]     addr_q,   addr_d;
  logic [63:0]     wdata_q,  wdata_d;
  logic [1:0]      size_q,   size_d;
  logic            req_q,    req_d;

  logic        gnt_if;
  logic        gnt_me;
  logic        fin;
  logic [63:0] done_rdata;
  logic [1:0]  done_resp;

  assign gnt_if = (state_q == S_GNT_IF);
  assign gnt_me = (state_q == S_GNT_ME);
  // A real bus completion wins over a watchdog expiry in the same cycle.
  assign fin        = (gnt_if | gnt_me) & (bus_ready_i | (wdog_q == WDOG_LAST));
  assign done_rdata = bus_ready_i ? bus_rdata_i : 64'd0;
  assign done_resp  = bus_ready_i ? bus_resp_i  : 2'b10;

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    wdog_d   = wdog_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    size_d   = size_q;
    req_d    = req_q;
    case (state_q)
      S_IDLE: begin
        if (me_valid_i && (!if_valid_i || (starve_q < STARVE_LIMIT))) begin
          state_d = S_GNT_ME;
          addr_d  = me_addr_i;
          wdata_d = me_wdata_i;
          size_d  = me_size_i;
          req_d   = me_req_i;
          wdog_d  = '0;
          if (!if_valid_i)
            starve_d = '0;
          else if (starve_q < STARVE_LIMIT)
            starve_d = starve_q + 1'b1;
        end else if (if_valid_i) begin
          state_d  = S_GNT_IF;
          addr_d   = if_addr_i;
          wdata_d  = 64'd0;
          size_d   = if_size_i;
          req_d    = 1'b0;
          wdog_d   = '0;
          starve_d = '0;
        end else begin
          starve_d = '0;
        end
      end
      S_GNT_IF, S_GNT_ME: begin
        if (fin)
          state_d = S_IDLE;
        else
          wdog_d = wdog_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      starve_q <= '0;
      wdog_q   <= '0;
      addr_q   <= 64'd0;
      wdata_q  <= 64'd0;
      size_q   <= 2'd0;
      req_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      wdog_q   <= wdog_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      size_q   <= size_d;
      req_q    <= req_d;
    end
  end

  assign bus_valid_o = gnt_if | gnt_me;
  assign bus_req_o   = req_q;
  assign bus_addr_o  = addr_q;
  assign bus_wdata_o = wdata_q;
  assign bus_size_o  = size_q;

  assign if_ready_o  = gnt_if & fin;
  assign if_rdata_o  = if_ready_o ? done_rdata : 64'd0;
  assign if_resp_o   = if_ready_o ? done_resp  : 2'b00;
  assign me_ready_o  = gnt_me & fin;
  assign me_rdata_o  = me_ready_o ? done_rdata : 64'd0;
  assign me_resp_o   = me_ready_o ? done_resp  : 2'b00;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Self-checking bench for mem_arbiter: vector table plus
//            scoreboarded multi-grant sequences.
// Revision : 1.0  initial release
// ============================================================================
module tb_mem_arbiter;

  typedef struct {
    logic        is_me;
    logic        req;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [1:0]  size;
    int          wait_n;
    logic [63:0] brdata;
    logic [1:0]  bresp;
    int          exp_k;
    logic        exp_req;
    logic [63:0] exp_wdata;
    logic [63:0] exp_rdata;
    logic [1:0]  exp_resp;
  } vec_t;

  typedef struct {
    logic        is_me;
    int          k;
    logic        req;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [1:0]  size;
    logic [63:0] rdata;
    logic [1:0]  resp;
  } sb_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_valid_i, me_valid_i, me_req_i;
  logic [63:0] if_addr_i, me_addr_i, me_wdata_i, bus_rdata_i;
  logic [1:0]  if_size_i, me_size_i, bus_resp_i;
  logic        bus_ready_i = 1'b0;
  logic        if_ready_o, me_ready_o, bus_valid_o, bus_req_o;
  logic [63:0] if_rdata_o, me_rdata_o, bus_addr_o, bus_wdata_o;
  logic [1:0]  if_resp_o, me_resp_o, bus_size_o;

  int   checks = 0;
  int   passes = 0;
  int   cyc = 0;
  int   gcnt = 0;
  int   bus_wait = 1;
  int   done_cnt = 0;
  int   last_rdy_cyc = 0;
  sb_t  sbq[$];
  sb_t  mon_e;
  vec_t vecs[8];

  mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .if_valid_i(if_valid_i), .if_addr_i(if_addr_i), .if_size_i(if_size_i),
    .if_ready_o(if_ready_o), .if_rdata_o(if_rdata_o), .if_resp_o(if_resp_o),
    .me_valid_i(me_valid_i), .me_req_i(me_req_i), .me_addr_i(me_addr_i),
    .me_wdata_i(me_wdata_i), .me_size_i(me_size_i),
    .me_ready_o(me_ready_o), .me_rdata_o(me_rdata_o), .me_resp_o(me_resp_o),
    .bus_valid_o(bus_valid_o), .bus_req_o(bus_req_o), .bus_addr_o(bus_addr_o),
    .bus_wdata_o(bus_wdata_o), .bus_size_o(bus_size_o),
    .bus_ready_i(bus_ready_i), .bus_rdata_i(bus_rdata_i), .bus_resp_i(bus_resp_i)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic sb_t mk(input logic is_me, input int k, input logic req,
                             input logic [63:0] addr, input logic [63:0] wdata,
                             input logic [1:0] size, input logic [63:0] rdata,
                             input logic [1:0] resp);
    sb_t e;
    e.is_me = is_me; e.k = k; e.req = req; e.addr = addr;
    e.wdata = wdata; e.size = size; e.rdata = rdata; e.resp = resp;
    return e;
  endfunction

  // Bus model: counts grant cycles and strobes ready in grant cycle bus_wait (0 = never).
  always @(posedge clk) begin
    #1;
    if (bus_valid_o) gcnt = gcnt + 1;
    else gcnt = 0;
    bus_ready_i = bus_valid_o && (bus_wait != 0) && (gcnt == bus_wait);
  end

  always @(negedge clk) begin
    if (if_ready_o || me_ready_o) begin
      done_cnt++;
      last_rdy_cyc = cyc;
      if (sbq.size() == 0) begin
        chk("unexpected_ready", {62'd0, if_ready_o, me_ready_o}, 64'd0);
      end else begin
        mon_e = sbq.pop_front();
        chk("who", {62'd0, if_ready_o, me_ready_o}, {62'd0, !mon_e.is_me, mon_e.is_me});
        chk("rdata", mon_e.is_me ? me_rdata_o : if_rdata_o, mon_e.rdata);
        chk("resp", {62'd0, mon_e.is_me ? me_resp_o : if_resp_o}, {62'd0, mon_e.resp});
        chk("gnt_cycles", 64'(gcnt), 64'(mon_e.k));
        chk("bus_req_size", {61'd0, bus_req_o, bus_size_o}, {61'd0, mon_e.req, mon_e.size});
        chk("bus_addr", bus_addr_o, mon_e.addr);
        chk("bus_wdata", bus_wdata_o, mon_e.wdata);
        chk("quiet_rdata", mon_e.is_me ? if_rdata_o : me_rdata_o, 64'd0);
        chk("quiet_resp", {62'd0, mon_e.is_me ? if_resp_o : me_resp_o}, 64'd0);
      end
    end
  end

  task automatic wait_done(input int tgt, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #2;
      if (done_cnt >= tgt) break;
    end
    chk("done_reached", {63'd0, done_cnt >= tgt}, 64'd1);
  endtask

  task automatic wait_gcnt(input int n, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #2;
      if (gcnt == n) break;
    end
    chk("grant_reached", 64'(gcnt), 64'(n));
  endtask

  task automatic apply_vec(input vec_t v);
    int tgt;
    int t0;
    bus_wait    = v.wait_n;
    bus_rdata_i = v.brdata;
    bus_resp_i  = v.bresp;
    sbq.push_back(mk(v.is_me, v.exp_k, v.exp_req, v.addr, v.exp_wdata, v.size,
                     v.exp_rdata, v.exp_resp));
    tgt = done_cnt + 1;
    t0  = cyc;
    if (v.is_me) begin
      me_valid_i = 1'b1; me_req_i = v.req; me_addr_i = v.addr;
      me_wdata_i = v.wdata; me_size_i = v.size;
    end else begin
      if_valid_i = 1'b1; if_addr_i = v.addr; if_size_i = v.size;
    end
    wait_done(tgt, 400);
    chk("latency", 64'(last_rdy_cyc - t0), 64'(v.exp_k));
    if_valid_i = 1'b0;
    me_valid_i = 1'b0;
    @(posedge clk); #2;
  endtask

  initial begin
    vecs[0] = '{1'b0, 1'b0, 64'h8000_0000, 64'h0, 2'b11, 3, 64'h1122_3344_5566_7788, 2'b00,
                3, 1'b0, 64'h0, 64'h1122_3344_5566_7788, 2'b00};
    vecs[1] = '{1'b1, 1'b0, 64'h1000, 64'hFFFF, 2'b10, 1, 64'hCAFE, 2'b01,
                1, 1'b0, 64'hFFFF, 64'hCAFE, 2'b01};
    vecs[2] = '{1'b1, 1'b1, 64'h2008, 64'hDEAD_BEEF, 2'b01, 2, 64'h0, 2'b00,
                2, 1'b1, 64'hDEAD_BEEF, 64'h0, 2'b00};
    vecs[3] = '{1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0, 2'b00, 1, 64'hAAAA_5555_AAAA_5555, 2'b11,
                1, 1'b0, 64'h0, 64'hAAAA_5555_AAAA_5555, 2'b11};
    vecs[4] = '{1'b1, 1'b1, 64'h0123_4567_89AB_CDE0, 64'h0F0F, 2'b11, 4, 64'h42, 2'b10,
                4, 1'b1, 64'h0F0F, 64'h42, 2'b10};
    vecs[5] = '{1'b0, 1'b0, 64'h8000_0040, 64'h0, 2'b10, 0, 64'h5A5A, 2'b01,
                255, 1'b0, 64'h0, 64'h0, 2'b10};
    vecs[6] = '{1'b1, 1'b1, 64'h9000, 64'h77, 2'b11, 0, 64'h1, 2'b00,
                255, 1'b1, 64'h77, 64'h0, 2'b10};
    vecs[7] = '{1'b1, 1'b0, 64'hA000, 64'h0, 2'b10, 255, 64'h7777, 2'b01,
                255, 1'b0, 64'h0, 64'h7777, 2'b01};

    rst_n = 1'b0;
    if_valid_i = 1'b0; if_addr_i = 64'h0; if_size_i = 2'b00;
    me_valid_i = 1'b0; me_req_i = 1'b0; me_addr_i = 64'h0; me_wdata_i = 64'h0; me_size_i = 2'b00;
    bus_rdata_i = 64'h0; bus_resp_i = 2'b00;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_ctrl", {58'd0, bus_valid_o, bus_req_o, bus_size_o, if_ready_o, me_ready_o}, 64'd0);
    chk("rst_addr", bus_addr_o, 64'd0);
    chk("rst_wdata", bus_wdata_o, 64'd0);
    chk("rst_rdata", if_rdata_o | me_rdata_o, 64'd0);
    chk("rst_resp", {60'd0, if_resp_o, me_resp_o}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #2;
    chk("idle_no_req", {63'd0, bus_valid_o}, 64'd0);

    for (int i = 0; i < 8; i++) apply_vec(vecs[i]);

    // Simultaneous requests: ME first, IF after the bubble.
    bus_wait = 2; bus_rdata_i = 64'h600D; bus_resp_i = 2'b00;
    sbq.push_back(mk(1'b1, 2, 1'b1, 64'h5000, 64'hDEAD_BEEF, 2'b10, 64'h600D, 2'b00));
    sbq.push_back(mk(1'b0, 2, 1'b0, 64'h6000, 64'h0, 2'b11, 64'h600D, 2'b00));
    begin
      int t;
      t = done_cnt;
      me_valid_i = 1'b1; me_req_i = 1'b1; me_addr_i = 64'h5000;
      me_wdata_i = 64'hDEAD_BEEF; me_size_i = 2'b10;
      if_valid_i = 1'b1; if_addr_i = 64'h6000; if_size_i = 2'b11;
      wait_done(t + 1, 20);
      me_valid_i = 1'b0;
      wait_done(t + 2, 20);
      if_valid_i = 1'b0;
      @(posedge clk); #2;
    end

    // Starvation: two rounds of four ME grants then one IF grant.
    bus_wait = 1; bus_rdata_i = 64'h5; bus_resp_i = 2'b00;
    for (int r = 0; r < 2; r++) begin
      for (int j = 0; j < 4; j++)
        sbq.push_back(mk(1'b1, 1, 1'b1, 64'h3000, 64'h33, 2'b11, 64'h5, 2'b00));
      sbq.push_back(mk(1'b0, 1, 1'b0, 64'h4000, 64'h0, 2'b10, 64'h5, 2'b00));
    end
    begin
      int t;
      t = done_cnt;
      me_valid_i = 1'b1; me_req_i = 1'b1; me_addr_i = 64'h3000;
      me_wdata_i = 64'h33; me_size_i = 2'b11;
      if_valid_i = 1'b1; if_addr_i = 64'h4000; if_size_i = 2'b10;
      wait_done(t + 10, 100);
      me_valid_i = 1'b0; if_valid_i = 1'b0;
      @(posedge clk); #2;
    end

    // Latched fields hold while inputs change and valid drops mid-grant.
    bus_wait = 3; bus_rdata_i = 64'hBEEF; bus_resp_i = 2'b01;
    sbq.push_back(mk(1'b1, 3, 1'b1, 64'h7000, 64'h1234, 2'b01, 64'hBEEF, 2'b01));
    begin
      int t;
      t = done_cnt;
      me_valid_i = 1'b1; me_req_i = 1'b1; me_addr_i = 64'h7000;
      me_wdata_i = 64'h1234; me_size_i = 2'b01;
      wait_gcnt(2, 10);
      me_valid_i = 1'b0; me_req_i = 1'b0; me_addr_i = 64'h9999;
      me_wdata_i = 64'h0; me_size_i = 2'b11;
      wait_done(t + 1, 10);
      @(posedge clk); #2;
    end

    // Reset in the second ME grant cycle abandons the transfer.
    bus_wait = 3;
    me_valid_i = 1'b1; me_req_i = 1'b1; me_addr_i = 64'hB000;
    me_wdata_i = 64'h99; me_size_i = 2'b11;
    wait_gcnt(2, 10);
    rst_n = 1'b0;
    #1;
    chk("rst_async_ctrl", {61'd0, bus_valid_o, bus_req_o, me_ready_o}, 64'd0);
    chk("rst_async_addr", bus_addr_o, 64'd0);
    me_valid_i = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk); #2;
    apply_vec('{1'b0, 1'b0, 64'hC000, 64'h0, 2'b11, 1, 64'hF00D, 2'b00,
                1, 1'b0, 64'h0, 64'hF00D, 2'b00});

    repeat (5) @(posedge clk);
    chk("sb_drained", 64'(sbq.size()), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
